// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
//
// Walks the frame_tracker through one full scan of the cell grid for every
// game frame. Each cell that the tracker reports as changed is captured into
// a one-entry valid/ready buffer for the LCD draw engine. The scan stalls
// whenever that buffer is full and the draw engine is not accepting.
//
// Optional feature macro: FRAME_SKIP_CNT_EN
//   When defined, adds a saturating count of game ticks that were merged
//   into an already-pending frame request (skip_cnt). The count clears when
//   frame_done pulses.
//
// Ports:
//   clk          system clock
//   nrst         synchronous, active-high reset
//   game_tick    one-cycle pulse: a new game frame is ready to scan
//   redraw_all   sampled with game_tick: clear tracker memory before the scan
//   trk_x/trk_y  tracker current cell position
//   trk_code     tracker object code at the current cell
//   trk_diff     tracker reports the current cell changed
//   trk_enable   advance the tracker by one cell
//   trk_sync     clear the tracker frame memory
//   draw_valid   draw request pending
//   draw_ready   draw engine accepts the pending request
//   draw_x/y     cell position of the pending request
//   draw_code    object code of the pending request
//   busy         scheduler is working on a frame
//   frame_done   one-cycle pulse: frame scanned and buffer drained
//   align_err    sticky: a scan started with the tracker not at (0,0)
//   skip_cnt     (FRAME_SKIP_CNT_EN only) dropped-frame counter
// ---------------------------------------------------------------------------
module frame_scheduler #(
  parameter int CELLS_X = 16,
  parameter int CELLS_Y = 12,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       game_tick,
  input  logic       redraw_all,
  input  logic [3:0] trk_x,
  input  logic [3:0] trk_y,
  input  logic [2:0] trk_code,
  input  logic       trk_diff,
  output logic       trk_enable,
  output logic       trk_sync,
  output logic       draw_valid,
  input  logic       draw_ready,
  output logic [3:0] draw_x,
  output logic [3:0] draw_y,
  output logic [2:0] draw_code,
  output logic       busy,
  output logic       frame_done,
  output logic       align_err
`ifdef FRAME_SKIP_CNT_EN
  ,
  output logic [7:0] skip_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(CELLS_X * CELLS_Y - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cell_cnt;
  logic             pending;
  logic             pending_redraw;

  logic             start_frame;
  logic             start_redraw;
  logic             accept;
  logic             load;

  // A frame starts from IDLE on a live tick or on a tick remembered while
  // busy. A redraw request from either source forces the CLEAR step.
  assign start_frame  = game_tick | pending;
  assign start_redraw = (game_tick & redraw_all) | (pending & pending_redraw);

  // The tracker may only advance when the buffer has room this cycle, either
  // because it is empty or because its current entry is being accepted.
  assign accept     = draw_valid & draw_ready;
  assign trk_enable = (state == SCAN) & (~draw_valid | draw_ready);
  assign load       = trk_enable & trk_diff;

  // Frame sequencing, pending-tick bookkeeping and registered status flags.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state          <= IDLE;
      cell_cnt       <= '0;
      pending        <= 1'b0;
      pending_redraw <= 1'b0;
      trk_sync       <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
      align_err      <= 1'b0;
    end else begin
      trk_sync   <= 1'b0;
      frame_done <= 1'b0;

      // Ticks that arrive while busy collapse into one pending request.
      if ((state != IDLE) && game_tick) begin
        pending        <= 1'b1;
        pending_redraw <= pending_redraw | redraw_all;
      end

      case (state)
        IDLE: begin
          if (start_frame) begin
            pending        <= 1'b0;
            pending_redraw <= 1'b0;
            busy           <= 1'b1;
            if (start_redraw) begin
              state    <= CLEAR;
              trk_sync <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end

        CLEAR: begin
          state <= SCAN;
        end

        SCAN: begin
          // The buffer is always empty when SCAN is entered, so the first
          // cell is always enabled and cell_cnt==0 marks the first cycle.
          if ((cell_cnt == '0) && ((trk_x != 4'd0) || (trk_y != 4'd0))) begin
            align_err <= 1'b1;
          end
          if (trk_enable) begin
            if (cell_cnt == LAST_CELL) begin
              cell_cnt <= '0;
              state    <= DRAIN;
            end else begin
              cell_cnt <= cell_cnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          // Leave as soon as the buffer is empty or empties on this edge.
          if (~draw_valid | draw_ready) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One-entry draw buffer. A reload takes priority over a plain accept so a
  // simultaneous accept-and-load keeps the entry valid with the new cell.
  always_ff @(posedge clk) begin
    if (nrst) begin
      draw_valid <= 1'b0;
      draw_x     <= 4'd0;
      draw_y     <= 4'd0;
      draw_code  <= 3'd0;
    end else if (load) begin
      draw_valid <= 1'b1;
      draw_x     <= trk_x;
      draw_y     <= trk_y;
      draw_code  <= trk_code;
    end else if (accept) begin
      draw_valid <= 1'b0;
    end
  end

`ifdef FRAME_SKIP_CNT_EN
  // Counts ticks that land on an already-pending request (a dropped frame).
  // Clearing on frame_done wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (nrst) begin
      skip_cnt <= 8'd0;
    end else if (frame_done) begin
      skip_cnt <= 8'd0;
    end else if (game_tick && pending && (skip_cnt != 8'hFF)) begin
      skip_cnt <= skip_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
//
// Drives frame_scheduler with a simple tracker model (a raster position that
// advances on trk_enable over a per-frame diff/code map) and compares the
// draw requests against the list of changed cells in visiting order.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;

  localparam int NCELLS = 192;

  logic       clk;
  logic       nrst;
  logic       game_tick;
  logic       redraw_all;
  logic [3:0] trk_x;
  logic [3:0] trk_y;
  logic [2:0] trk_code;
  logic       trk_diff;
  logic       trk_enable;
  logic       trk_sync;
  logic       draw_valid;
  logic       draw_ready;
  logic [3:0] draw_x;
  logic [3:0] draw_y;
  logic [2:0] draw_code;
  logic       busy;
  logic       frame_done;
  logic       align_err;
`ifdef FRAME_SKIP_CNT_EN
  logic [7:0] skip_cnt;
`endif

  frame_scheduler dut (
    .clk        (clk),
    .nrst       (nrst),
    .game_tick  (game_tick),
    .redraw_all (redraw_all),
    .trk_x      (trk_x),
    .trk_y      (trk_y),
    .trk_code   (trk_code),
    .trk_diff   (trk_diff),
    .trk_enable (trk_enable),
    .trk_sync   (trk_sync),
    .draw_valid (draw_valid),
    .draw_ready (draw_ready),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_code  (draw_code),
    .busy       (busy),
    .frame_done (frame_done),
    .align_err  (align_err)
`ifdef FRAME_SKIP_CNT_EN
    ,
    .skip_cnt   (skip_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Tracker model: raster position over the grid, advanced by trk_enable.
  int         pos      = 0;
  bit         pos_load = 1'b0;
  int         load_pos = 0;
  logic       diff_map [NCELLS];
  logic [2:0] code_map [NCELLS];

  always @(posedge clk) begin
    if (pos_load) pos <= load_pos;
    else if (trk_enable === 1'b1) pos <= (pos == NCELLS - 1) ? 0 : pos + 1;
  end

  assign trk_x    = 4'(pos % 16);
  assign trk_y    = 4'(pos / 16);
  assign trk_code = code_map[pos];
  assign trk_diff = diff_map[pos];

  // Observation at the falling edge, away from the active edge.
  int          en_total       = 0;
  int          sync_total     = 0;
  int          sync_en_bad    = 0;
  int          sync_then_scan = 0;
  int          done_total     = 0;
  int          last_done_cyc  = 0;
  int          hold_viol      = 0;
  bit          prev_sync      = 1'b0;
  bit          prev_hold      = 1'b0;
  logic [10:0] prev_data      = '0;
  logic [10:0] got_q [$];

  always @(negedge clk) begin
    if (nrst) begin
      prev_sync = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (trk_enable) en_total++;
      if (trk_sync) sync_total++;
      if (trk_sync && trk_enable) sync_en_bad++;
      if (prev_sync && trk_enable) sync_then_scan++;
      if (prev_hold && (!draw_valid || ({draw_x, draw_y, draw_code} != prev_data))) hold_viol++;
      if (draw_valid && draw_ready) got_q.push_back({draw_x, draw_y, draw_code});
      if (frame_done) begin
        done_total++;
        last_done_cyc = cyc;
      end
      prev_sync = trk_sync;
      prev_hold = draw_valid && !draw_ready;
      prev_data = {draw_x, draw_y, draw_code};
    end
  end

  int tick_cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pulseTick(input bit redraw);
    game_tick  = 1'b1;
    redraw_all = redraw;
    tick_cyc   = cyc;
    step();
    game_tick  = 1'b0;
    redraw_all = 1'b0;
  endtask

  task automatic waitDone(input int bound, input bit rand_ready, output bit timed_out);
    int start_done;
    start_done = done_total;
    timed_out  = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (done_total != start_done) break;
      if (rand_ready) draw_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    if (done_total != start_done) timed_out = 1'b0;
    draw_ready = 1'b1;
  endtask

  task automatic applyStimulus(input string tag, input bit redraw, input bit rand_ready);
    bit to;
    pulseTick(redraw);
    waitDone(3000, rand_ready, to);
    checkOutput({tag, "_timeout"}, 32'(to), 0);
  endtask

  // Reference: changed cells in the order the tracker visits them.
  task automatic checkFrame(input string tag, input int start_pos, input int base);
    logic [10:0] exp_q [$];
    int mism;
    for (int i = 0; i < NCELLS; i++) begin
      int p;
      p = (start_pos + i) % NCELLS;
      if (diff_map[p]) exp_q.push_back({4'(p % 16), 4'(p / 16), code_map[p]});
    end
    checkOutput({tag, "_req_count"}, got_q.size() - base, exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && (base + i) < got_q.size(); i++) begin
      if (got_q[base + i] !== exp_q[i]) mism++;
    end
    checkOutput({tag, "_req_data"}, mism, 0);
  endtask

  task automatic fillMap(input int density);
    for (int p = 0; p < NCELLS; p++) begin
      diff_map[p] = ($urandom_range(0, 99) < density);
      code_map[p] = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    int  en0;
    int  sync0;
    int  scan0;
    int  base;
    int  d0;
    int  d1;
    int  t0;
    bit  found;
    bit  to;

    nrst       = 1'b1;
    game_tick  = 1'b0;
    redraw_all = 1'b0;
    draw_ready = 1'b1;
    pos_load   = 1'b1;
    load_pos   = 0;
    fillMap(0);
    repeat (3) step();

    // Reset values
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_draw_valid", 32'(draw_valid), 0);
    checkOutput("rst_trk_enable", 32'(trk_enable), 0);
    checkOutput("rst_trk_sync", 32'(trk_sync), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_align_err", 32'(align_err), 0);
    checkOutput("rst_draw_data", 32'({draw_x, draw_y, draw_code}), 0);
`ifdef FRAME_SKIP_CNT_EN
    checkOutput("rst_skip_cnt", 32'(skip_cnt), 0);
`endif
    nrst     = 1'b0;
    pos_load = 1'b0;
    step();

    // Single changed cell at (3,2), no redraw
    fillMap(0);
    diff_map[2 * 16 + 3] = 1'b1;
    en0 = en_total; sync0 = sync_total; base = got_q.size();
    applyStimulus("A", 1'b0, 1'b0);
    checkOutput("A_enables", en_total - en0, NCELLS);
    checkFrame("A", 0, base);
    checkOutput("A_done_latency", last_done_cyc - tick_cyc, 194);
    checkOutput("A_no_sync", sync_total - sync0, 0);
    checkOutput("A_tracker_home", pos, 0);
    checkOutput("A_idle", 32'(busy), 0);
    checkOutput("A_align_err", 32'(align_err), 0);

    // Redraw: one CLEAR cycle, then the scan
    fillMap(25);
    en0 = en_total; sync0 = sync_total; scan0 = sync_then_scan; base = got_q.size();
    applyStimulus("B", 1'b1, 1'b0);
    checkOutput("B_sync_cycles", sync_total - sync0, 1);
    checkOutput("B_sync_no_enable", sync_en_bad, 0);
    checkOutput("B_scan_after_sync", sync_then_scan - scan0, 1);
    checkOutput("B_done_latency", last_done_cyc - tick_cyc, 195);
    checkOutput("B_enables", en_total - en0, NCELLS);
    checkFrame("B", 0, base);

    // Back-pressure on the request for (5,5)
    fillMap(0);
    diff_map[5 * 16 + 5] = 1'b1;
    en0 = en_total; base = got_q.size();
    pulseTick(1'b0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (draw_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checkOutput("C_valid_seen", 32'(found), 1);
    draw_ready = 1'b0;
    d0 = en_total;
    repeat (5) step();
    checkOutput("C_hold_x", 32'(draw_x), 5);
    checkOutput("C_hold_y", 32'(draw_y), 5);
    checkOutput("C_hold_code", 32'(draw_code), 32'(code_map[85]));
    checkOutput("C_stalled_enable", 32'(trk_enable), 0);
    repeat (5) step();
    checkOutput("C_stall_enables", en_total - d0, 0);
    draw_ready = 1'b1;
    #1;
    checkOutput("C_resume", 32'(trk_enable), 1);
    waitDone(400, 1'b0, to);
    checkOutput("C_timeout", 32'(to), 0);
    checkOutput("C_enables", en_total - en0, NCELLS);
    checkFrame("C", 0, base);
    checkOutput("C_hold_rule", hold_viol, 0);

    // Every cell changed, draw_ready high: full-rate scan
    for (int p = 0; p < NCELLS; p++) begin
      diff_map[p] = 1'b1;
      code_map[p] = 3'($urandom_range(0, 7));
    end
    en0 = en_total; base = got_q.size();
    applyStimulus("D", 1'b0, 1'b0);
    checkOutput("D_done_latency", last_done_cyc - tick_cyc, 194);
    checkOutput("D_enables", en_total - en0, NCELLS);
    checkFrame("D", 0, base);

    // Randomized maps with random back-pressure
    for (int f = 0; f < 3; f++) begin
      fillMap($urandom_range(10, 60));
      en0 = en_total; base = got_q.size();
      applyStimulus("E", 1'b0, 1'b1);
      checkOutput("E_enables", en_total - en0, NCELLS);
      checkFrame("E", 0, base);
      checkOutput("E_tracker_home", pos, 0);
    end
    checkOutput("E_hold_rule", hold_viol, 0);

    // Three extra ticks during a scan merge into one extra frame
    fillMap(0);
    en0 = en_total; d0 = done_total;
    pulseTick(1'b0);
    t0 = tick_cyc;
    repeat (20) step();
    pulseTick(1'b0);
    repeat (20) step();
    pulseTick(1'b0);
    repeat (20) step();
    pulseTick(1'b0);
    checkOutput("F_busy", 32'(busy), 1);
`ifdef FRAME_SKIP_CNT_EN
    checkOutput("F_skip_before", 32'(skip_cnt), 2);
`endif
    waitDone(400, 1'b0, to);
    checkOutput("F_timeout1", 32'(to), 0);
    checkOutput("F_done1_latency", last_done_cyc - t0, 194);
    d1 = last_done_cyc;
`ifdef FRAME_SKIP_CNT_EN
    checkOutput("F_skip_after", 32'(skip_cnt), 0);
`endif
    waitDone(400, 1'b0, to);
    checkOutput("F_timeout2", 32'(to), 0);
    checkOutput("F_done_gap", last_done_cyc - d1, 195);
    repeat (300) step();
    checkOutput("F_frame_count", done_total - d0, 2);
    checkOutput("F_enables", en_total - en0, 2 * NCELLS);

    // Reset mid-scan with a request in flight
    for (int p = 0; p < NCELLS; p++) diff_map[p] = 1'b1;
    pulseTick(1'b0);
    repeat (30) step();
    draw_ready = 1'b0;
    repeat (2) step();
    checkOutput("G_valid_before_rst", 32'(draw_valid), 1);
    nrst = 1'b1;
    step();
    checkOutput("G_rst_valid", 32'(draw_valid), 0);
    checkOutput("G_rst_busy", 32'(busy), 0);
    checkOutput("G_rst_enable", 32'(trk_enable), 0);
    checkOutput("G_rst_sync", 32'(trk_sync), 0);
    checkOutput("G_rst_done", 32'(frame_done), 0);
    checkOutput("G_rst_data", 32'({draw_x, draw_y, draw_code}), 0);
    nrst       = 1'b0;
    draw_ready = 1'b1;
    pos_load   = 1'b1;
    load_pos   = 7;
    step();
    pos_load = 1'b0;
    d0 = done_total;
    repeat (5) step();
    checkOutput("G_no_stray_frame", done_total - d0, 0);
    checkOutput("G_align_clear", 32'(align_err), 0);
    fillMap(30);
    en0 = en_total; base = got_q.size();
    applyStimulus("G", 1'b0, 1'b1);
    checkOutput("G_align_err", 32'(align_err), 1);
    checkOutput("G_enables", en_total - en0, NCELLS);
    checkFrame("G", 7, base);
    checkOutput("G_tracker_end", pos, 7);

    // align_err is cleared only by reset
    nrst = 1'b1;
    step();
    nrst = 1'b0;
    step();
    checkOutput("H_align_after_rst", 32'(align_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
